pattern_sequencer: RTL and testbench

//  Parametrised next-generation pattern display engine for the memory game. On a start pulse it

---
 rtl/pattern_sequencer_pkg.sv | 37 +++
 rtl/pattern_sequencer_tick_gen.sv | 40 ++++
 rtl/pattern_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_pattern_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pattern_sequencer_pkg
// Shared definitions for the memory-game pattern display blocks:
//   - LEVEL_W      : width of the game difficulty level
//   - seq_state_t  : playback state encoding (IDLE / ON / GAP / DONE)
//   - clog2        : elaboration-time ceiling log2, never smaller than 1
//   - onehot_bit   : one bit of the one-hot decode of a pattern symbol
// No ports; imported by tick_gen and pattern_sequencer.
// ---------------------------------------------------------------------------
package pattern_sequencer_pkg;

   localparam int LEVEL_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_t;

   // Minimum of 1 so a degenerate parameter never yields a zero-width vector.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

   // Bit 'pos' of the one-hot code for symbol 'idx'. A symbol beyond the
   // last LED matches no position, so out-of-range entries decode to dark.
   function automatic logic onehot_bit(input int idx, input int pos);
      return (idx == pos);
   endfunction

endpackage

// File: rtl/pattern_sequencer_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Divides the fast system clock into a 1-cycle tick strobe every TICK_DIV
// cycles. Shared by the game timing blocks.
// Ports:
//   clk_1  in   system clock
//   rst    in   synchronous active-high reset
//   clr    in   restart the divider so the next tick is TICK_DIV cycles away
//   tick   out  strobe, high in the last cycle of each TICK_DIV period
// ---------------------------------------------------------------------------
module tick_gen
   import pattern_sequencer_pkg::*;
#(
   parameter int TICK_DIV = 1000
) (
   input  logic clk_1,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = clog2(TICK_DIV);

   logic [CNT_W-1:0] count;

   // Free-running modulo-TICK_DIV counter; clearing it realigns the tick
   // phase so the first tick lands exactly TICK_DIV cycles after clr.
   always_ff @(posedge clk_1) begin
      if (rst || clr) begin
         count <= '0;
      end else if (count == CNT_W'(TICK_DIV - 1)) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign tick = (count == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/pattern_sequencer.sv
// ---------------------------------------------------------------------------
// pattern_sequencer
// Memory-game pattern display engine. On start it snapshots the pattern and
// the level, then plays the first 'steps' entries as one-hot LED flashes,
// each followed by a dark gap, and pulses done at the end.
// Ports:
//   clk_1     in   system clock
//   rst       in   synchronous active-high reset
//   start     in   begin playback (only honoured in IDLE)
//   abort     in   cancel playback, back to IDLE without done
//   level     in   difficulty, sampled with start
//   pattern   in   packed entries, entry i at [i*IDX_W +: IDX_W]
//   led       out  registered one-hot flash
//   busy      out  playback in progress
//   done      out  1-cycle pulse when the last gap ends
//   step_idx  out  index of the step currently shown
// ---------------------------------------------------------------------------
module pattern_sequencer
   import pattern_sequencer_pkg::*;
#(
   parameter int NUM_LEDS      = 8,
   parameter int IDX_W         = 3,
   parameter int MAX_STEPS     = 16,
   parameter int TICK_DIV      = 1000,
   parameter int BASE_STEPS    = 4,
   parameter int ON_BASE_TICKS = 5,
   parameter int GAP_TICKS     = 1
) (
   input  logic                         clk_1,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   input  logic [LEVEL_W-1:0]           level,
   input  logic [MAX_STEPS*IDX_W-1:0]   pattern,
   output logic [NUM_LEDS-1:0]          led,
   output logic                         busy,
   output logic                         done,
   output logic [clog2(MAX_STEPS)-1:0]  step_idx
);

   localparam int STEP_W    = clog2(MAX_STEPS);
   localparam int STEPS_W   = clog2(MAX_STEPS + 1);
   localparam int PHASE_MAX = (ON_BASE_TICKS > GAP_TICKS) ? ON_BASE_TICKS : GAP_TICKS;
   localparam int PHASE_W   = clog2(PHASE_MAX + 1);
   localparam int PAT_W     = MAX_STEPS * IDX_W;

   seq_state_t          state, state_n;
   logic [NUM_LEDS-1:0] led_n;
   logic                busy_n, done_n;
   logic [STEP_W-1:0]   step_n, next_idx;
   logic [PHASE_W-1:0]  phase, phase_n;
   logic [PAT_W-1:0]    pattern_q, pattern_n;
   logic [STEPS_W-1:0]  steps_q, steps_n;
   logic [PHASE_W-1:0]  on_ticks_q, on_ticks_n;
   logic                tick, tick_clr, advance;
   int                  steps_calc, on_ticks_calc;

   function automatic logic [NUM_LEDS-1:0] decode(input logic [IDX_W-1:0] idx);
      logic [NUM_LEDS-1:0] vec;
      vec = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         vec[i] = onehot_bit(int'(idx), i);
      end
      return vec;
   endfunction

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_1 (clk_1),
      .rst   (rst),
      .clr   (tick_clr),
      .tick  (tick)
   );

   // Round parameters derived from the level: higher levels play more steps
   // (clipped to the storage depth) with shorter flashes (never below one tick).
   always_comb begin
      steps_calc    = BASE_STEPS + 2 * int'(level);
      on_ticks_calc = ON_BASE_TICKS - int'(level);
      if (steps_calc > MAX_STEPS) begin
         steps_calc = MAX_STEPS;
      end
      if (on_ticks_calc < 1) begin
         on_ticks_calc = 1;
      end
   end

   // Next-state and next-output logic. The phase counter counts ticks inside
   // the current ON or GAP interval; 'advance' marks the end of a full step
   // so the step-to-step handoff is written once for both the gap and the
   // gapless configuration.
   always_comb begin
      state_n    = state;
      led_n      = led;
      busy_n     = busy;
      done_n     = 1'b0;
      step_n     = step_idx;
      phase_n    = phase;
      pattern_n  = pattern_q;
      steps_n    = steps_q;
      on_ticks_n = on_ticks_q;
      tick_clr   = 1'b0;
      advance    = 1'b0;
      next_idx   = step_idx + STEP_W'(1);

      case (state)
         ST_IDLE: begin
            led_n  = '0;
            busy_n = 1'b0;
            if (start && !abort) begin
               state_n    = ST_ON;
               pattern_n  = pattern;
               steps_n    = STEPS_W'(steps_calc);
               on_ticks_n = PHASE_W'(on_ticks_calc);
               step_n     = '0;
               phase_n    = '0;
               busy_n     = 1'b1;
               tick_clr   = 1'b1;
               led_n      = decode(pattern[IDX_W-1:0]);
            end
         end
         ST_ON: begin
            if (abort) begin
               state_n = ST_IDLE;
               led_n   = '0;
               busy_n  = 1'b0;
               phase_n = '0;
            end else if (tick) begin
               if ((phase + PHASE_W'(1)) == on_ticks_q) begin
                  phase_n = '0;
                  if (GAP_TICKS > 0) begin
                     state_n = ST_GAP;
                     led_n   = '0;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  phase_n = phase + PHASE_W'(1);
               end
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_n = ST_IDLE;
               led_n   = '0;
               busy_n  = 1'b0;
               phase_n = '0;
            end else if (tick) begin
               if ((phase + PHASE_W'(1)) == PHASE_W'(GAP_TICKS)) begin
                  phase_n = '0;
                  advance = 1'b1;
               end else begin
                  phase_n = phase + PHASE_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_n = ST_IDLE;
            led_n   = '0;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = ST_IDLE;
            led_n   = '0;
            busy_n  = 1'b0;
         end
      endcase

      if (advance) begin
         if ((STEPS_W'(step_idx) + STEPS_W'(1)) == steps_q) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            led_n   = '0;
         end else begin
            state_n = ST_ON;
            step_n  = next_idx;
            led_n   = decode(pattern_q[int'(next_idx) * IDX_W +: IDX_W]);
         end
      end
   end

   // State, snapshot and output registers. Every output is registered so the
   // LED pins never see decode glitches.
   always_ff @(posedge clk_1) begin
      if (rst) begin
         state      <= ST_IDLE;
         led        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         step_idx   <= '0;
         phase      <= '0;
         pattern_q  <= '0;
         steps_q    <= '0;
         on_ticks_q <= '0;
      end else begin
         state      <= state_n;
         led        <= led_n;
         busy       <= busy_n;
         done       <= done_n;
         step_idx   <= step_n;
         phase      <= phase_n;
         pattern_q  <= pattern_n;
         steps_q    <= steps_n;
         on_ticks_q <= on_ticks_n;
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pattern_sequencer
// Directed bench for pattern_sequencer with TICK_DIV=4. A second instance
// with NUM_LEDS=6 exercises out-of-range pattern entries and mid-run reset.
// ---------------------------------------------------------------------------
module tb_pattern_sequencer;

   logic        clk_1 = 1'b0;
   logic        rst, start, abort;
   logic [2:0]  level;
   logic [47:0] pattern;
   logic [7:0]  led;
   logic        busy, done;
   logic [3:0]  step_idx;

   logic        rst6, start6, abort6;
   logic [2:0]  level6;
   logic [47:0] pattern6;
   logic [5:0]  led6;
   logic        busy6, done6;
   logic [3:0]  step_idx6;

   int total = 0;
   int bad   = 0;

   always #5 clk_1 = ~clk_1;

   pattern_sequencer #(
      .TICK_DIV (4)
   ) dut (
      .clk_1    (clk_1),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .level    (level),
      .pattern  (pattern),
      .led      (led),
      .busy     (busy),
      .done     (done),
      .step_idx (step_idx)
   );

   pattern_sequencer #(
      .NUM_LEDS (6),
      .TICK_DIV (4)
   ) dut6 (
      .clk_1    (clk_1),
      .rst      (rst6),
      .start    (start6),
      .abort    (abort6),
      .level    (level6),
      .pattern  (pattern6),
      .led      (led6),
      .busy     (busy6),
      .done     (done6),
      .step_idx (step_idx6)
   );

   // Advance one clock and step 1 time unit past the edge, so inputs change
   // and outputs are sampled away from the active edge.
   task automatic cycle();
      @(posedge clk_1);
      #1;
   endtask

   // Expected LED value c cycles after the accepting edge, from the timing
   // rules: each step is (on+gap)*4 cycles, the first on*4 of them lit.
   function automatic logic [7:0] exp_led(input logic [47:0] pat, input int lvl,
                                          input int nleds, input int c);
      int on_t, per, s, off, idx;
      on_t = 5 - lvl;
      if (on_t < 1) on_t = 1;
      per = (on_t + 1) * 4;
      s   = c / per;
      off = c % per;
      if (off >= on_t * 4) return 8'h00;
      idx = int'(pat[s*3 +: 3]);
      if (idx >= nleds) return 8'h00;
      return 8'(1 << idx);
   endfunction

   function automatic int exp_per(input int lvl);
      int on_t;
      on_t = 5 - lvl;
      if (on_t < 1) on_t = 1;
      return (on_t + 1) * 4;
   endfunction

   function automatic int exp_steps(input int lvl);
      int s;
      s = 4 + 2 * lvl;
      if (s > 16) s = 16;
      return s;
   endfunction

   function automatic logic [47:0] pack(input int e0, e1, e2, e3, e4, e5, e6, e7,
                                        e8, e9, e10, e11, e12, e13, e14, e15);
      logic [47:0] p;
      int e [16];
      e = '{e0, e1, e2, e3, e4, e5, e6, e7, e8, e9, e10, e11, e12, e13, e14, e15};
      for (int i = 0; i < 16; i++) p[i*3 +: 3] = 3'(e[i]);
      return p;
   endfunction

   task automatic test_reset();
      rst = 1'b1; rst6 = 1'b1;
      start = 1'b0; abort = 1'b0; level = 3'd0; pattern = '0;
      start6 = 1'b0; abort6 = 1'b0; level6 = 3'd0; pattern6 = '0;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) begin
            rst = 1'b0; rst6 = 1'b0;
         end
         cycle();
         total++;
         if ({led, busy, done, step_idx} !== 14'h0) begin
            bad++;
            $display("[TB] FAIL reset_idle i=%0d got led=%h busy=%b done=%b step=%0d want all 0",
                     i, led, busy, done, step_idx);
         end
         total++;
         if ({led6, busy6, done6, step_idx6} !== 12'h0) begin
            bad++;
            $display("[TB] FAIL reset_idle6 i=%0d got led=%h busy=%b done=%b step=%0d want all 0",
                     i, led6, busy6, done6, step_idx6);
         end
      end
   endtask

   // level 2: 8 steps, 3 on ticks + 1 gap tick -> 16 cycles per step.
   task automatic test_level2_playback();
      logic [7:0] want;
      pattern = pack(0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7);
      level   = 3'd2;
      start   = 1'b1;
      cycle();
      start   = 1'b0;
      for (int c = 0; c < 128; c++) begin
         want = exp_led(pattern, 2, 8, c);
         total++;
         if (led !== want || busy !== 1'b1 || done !== 1'b0 || step_idx !== 4'(c / 16)) begin
            bad++;
            $display("[TB] FAIL lvl2_play c=%0d got led=%h busy=%b done=%b step=%0d want led=%h busy=1 done=0 step=%0d",
                     c, led, busy, done, step_idx, want, c / 16);
         end
         if (c == 11 || c == 12 || c == 16) begin
            total++;
            if (led !== ((c == 11) ? 8'h01 : (c == 12) ? 8'h00 : 8'h02)) begin
               bad++;
               $display("[TB] FAIL lvl2_edges c=%0d got led=%h", c, led);
            end
         end
         cycle();
      end
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || led !== 8'h00) begin
         bad++;
         $display("[TB] FAIL lvl2_done got done=%b busy=%b led=%h want done=1 busy=0 led=00",
                  done, busy, led);
      end
   endtask

   // Called in the done cycle: a start held from here is ignored in DONE and
   // accepted one cycle later in IDLE. Level 7 clips to 16 steps, 1 on tick.
   task automatic test_back_to_back();
      logic [7:0] want;
      pattern = pack(1, 6, 3, 0, 5, 2, 7, 4, 1, 6, 3, 0, 5, 2, 7, 4);
      level   = 3'd7;
      start   = 1'b1;
      cycle();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || led !== 8'h00) begin
         bad++;
         $display("[TB] FAIL start_in_done got busy=%b done=%b led=%h want 0 0 00", busy, done, led);
      end
      cycle();
      start = 1'b0;
      for (int c = 0; c < 128; c++) begin
         want = exp_led(pattern, 7, 8, c);
         total++;
         if (led !== want || busy !== 1'b1 || done !== 1'b0 || step_idx !== 4'(c / 8)) begin
            bad++;
            $display("[TB] FAIL lvl7_play c=%0d got led=%h busy=%b done=%b step=%0d want led=%h busy=1 done=0 step=%0d",
                     c, led, busy, done, step_idx, want, c / 8);
         end
         cycle();
      end
      total++;
      if (done !== 1'b1 || step_idx !== 4'd15) begin
         bad++;
         $display("[TB] FAIL lvl7_done got done=%b step=%0d want done=1 step=15", done, step_idx);
      end
      cycle();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL done_pulse_width got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   // level 0: 4 steps of 24 cycles. At step 3 the inputs change and start
   // is pulsed; the display must follow the original snapshot.
   task automatic test_ignore_restart();
      logic [47:0] snap;
      logic [7:0]  want;
      snap    = pack(4, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      pattern = snap;
      level   = 3'd0;
      start   = 1'b1;
      cycle();
      start   = 1'b0;
      for (int c = 0; c < 96; c++) begin
         want = exp_led(snap, 0, 8, c);
         total++;
         if (led !== want || busy !== 1'b1 || done !== 1'b0 || step_idx !== 4'(c / 24)) begin
            bad++;
            $display("[TB] FAIL restart_ignored c=%0d got led=%h busy=%b step=%0d want led=%h busy=1 step=%0d",
                     c, led, busy, step_idx, want, c / 24);
         end
         if (c == 72) begin
            pattern = pack(6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6);
            level   = 3'd7;
            start   = 1'b1;
         end
         if (c == 73) start = 1'b0;
         cycle();
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL restart_done got done=%b want 1", done);
      end
      cycle();
      cycle();
   endtask

   task automatic test_abort();
      logic [7:0] want;
      pattern = pack(3, 5, 0, 6, 2, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      level   = 3'd1;
      start   = 1'b1;
      cycle();
      start   = 1'b0;
      for (int c = 0; c < 83; c++) begin
         cycle();
      end
      total++;
      if (led !== 8'h04 || step_idx !== 4'd4 || busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL abort_pre got led=%h step=%0d busy=%b want 04 4 1", led, step_idx, busy);
      end
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      total++;
      if (led !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_stop got led=%h busy=%b done=%b want 00 0 0", led, busy, done);
      end
      for (int i = 0; i < 40; i++) begin
         cycle();
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || led !== 8'h00) begin
            bad++;
            $display("[TB] FAIL abort_quiet i=%0d got done=%b busy=%b led=%h want 0 0 00", i, done, busy, led);
         end
      end
      abort = 1'b1;
      start = 1'b1;
      cycle();
      abort = 1'b0;
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || led !== 8'h00) begin
         bad++;
         $display("[TB] FAIL abort_beats_start got busy=%b led=%h want 0 00", busy, led);
      end
      cycle();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL start_not_queued got busy=%b want 0", busy);
      end
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int c = 0; c < 120; c++) begin
         want = exp_led(pattern, 1, 8, c);
         total++;
         if (led !== want || busy !== 1'b1 || step_idx !== 4'(c / 20)) begin
            bad++;
            $display("[TB] FAIL replay c=%0d got led=%h busy=%b step=%0d want led=%h busy=1 step=%0d",
                     c, led, busy, step_idx, want, c / 20);
         end
         cycle();
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("[TB] FAIL replay_done got done=%b want 1", done);
      end
      cycle();
   endtask

   // NUM_LEDS=6: entries 7 and 6 have no LED and stay dark for a full step.
   task automatic test_small_led_count();
      logic [7:0] want8;
      logic [5:0] want;
      pattern6 = pack(2, 7, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      level6   = 3'd0;
      start6   = 1'b1;
      cycle();
      start6   = 1'b0;
      for (int c = 0; c < 50; c++) begin
         want8 = exp_led(pattern6, 0, 6, c);
         want  = want8[5:0];
         total++;
         if (led6 !== want || busy6 !== 1'b1 || step_idx6 !== 4'(c / exp_per(0))) begin
            bad++;
            $display("[TB] FAIL small_leds c=%0d got led=%h busy=%b step=%0d want led=%h busy=1 step=%0d",
                     c, led6, busy6, step_idx6, want, c / exp_per(0));
         end
         if (c == 0 || c == 30) begin
            total++;
            if (led6 !== ((c == 0) ? 6'h04 : 6'h00)) begin
               bad++;
               $display("[TB] FAIL small_leds_fixed c=%0d got led=%h", c, led6);
            end
         end
         cycle();
      end
      rst6 = 1'b1;
      cycle();
      rst6 = 1'b0;
      total++;
      if ({led6, busy6, done6, step_idx6} !== 12'h0) begin
         bad++;
         $display("[TB] FAIL mid_reset got led=%h busy=%b done=%b step=%0d want all 0",
                  led6, busy6, done6, step_idx6);
      end
      for (int i = 0; i < exp_steps(0) * 10; i++) begin
         cycle();
         total++;
         if (busy6 !== 1'b0 || done6 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle i=%0d got busy=%b done=%b want 0 0", i, busy6, done6);
         end
      end
   endtask

   initial begin
      test_reset();
      test_level2_playback();
      test_back_to_back();
      test_ignore_restart();
      test_abort();
      test_small_led_count();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
